// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the 4-digit seven-segment scan driver.
package seven_seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    typedef enum logic {
        GAP,
        ON
    } scan_state_e;

    typedef logic [1:0]                digit_idx_t;
    typedef logic [4*NUM_DIGITS-1:0]   bcd4_t;

    // Nibble of digit idx; digit 0 sits in the least significant nibble.
    function automatic logic [3:0] nibble_at(bcd4_t value, digit_idx_t idx);
        return value[{idx, 2'b00} +: 4];
    endfunction

    // Active-low one-hot enable for digit idx.
    function automatic logic [NUM_DIGITS-1:0] digit_enable_n(digit_idx_t idx);
        logic [NUM_DIGITS-1:0] en_n;
        en_n      = '1;
        en_n[idx] = 1'b0;
        return en_n;
    endfunction

    // True when digit idx is a leading zero: it and every digit above it are
    // zero. Digit 0 is never reported as a leading zero.
    function automatic logic leading_zero(bcd4_t value, digit_idx_t idx);
        logic all_zero;
        logic blank;
        all_zero = 1'b1;
        blank    = 1'b0;
        for (int unsigned d = NUM_DIGITS - 1; d >= 1; d--) begin
            all_zero = all_zero && (value[4*d +: 4] == 4'd0);
            if (digit_idx_t'(d) == idx) begin
                blank = all_zero;
            end
        end
        return blank;
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// Valid/ready input channel carrying a packed-BCD value to the scan driver.
interface seven_seg_scan_driver_if;
    import seven_seg_pkg::*;

    bcd4_t in_data;
    logic  in_valid;
    logic  in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/seven_seg_refresh_timer.sv
// Dwell counter and digit index for the display scan. Strobes are combinational
// and mark the clock edge that closes the current cycle:
//   gap_end    - next cycle is the first ON cycle of the slot
//   slot_start - next cycle is the first cycle of a new slot (counter wraps)
//   frame_end  - slot_start while the digit-3 slot is active
module seven_seg_refresh_timer
    import seven_seg_pkg::*;
#(
    parameter int unsigned DWELL      = 100000,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    output digit_idx_t idx,
    output logic       slot_start,
    output logic       gap_end,
    output logic       frame_end
);

    localparam int unsigned    CW       = $clog2(DWELL);
    localparam logic [CW-1:0]  LAST     = CW'(DWELL - 1);
    localparam logic [CW-1:0]  GAP_LAST = CW'(GAP_CYCLES - 1);

    logic [CW-1:0] count;

    // Count 0..DWELL-1 within a slot; advance the digit index on every wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            idx   <= '0;
        end else if (count == LAST) begin
            count <= '0;
            idx   <= idx + 1'b1;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign slot_start = (count == LAST);
    assign gap_end    = (count == GAP_LAST);
    assign frame_end  = slot_start && (idx == digit_idx_t'(NUM_DIGITS - 1));

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexes a 4-digit packed-BCD value onto a common-segment display.
// New values arrive over a valid/ready channel, wait in a one-entry pending
// register and are swapped onto the display only at frame boundaries, so a
// frame never mixes old and new digits. Each digit slot opens with a blanking
// gap; bcd_out changes at slot start and is stable for the whole ON period.
// Optional build macro SEVEN_SEG_LZ_BLANK_EN enables leading-zero blanking.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned DIGIT_HZ   = 1000,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seven_seg_scan_driver_if.slave host,
    output logic [3:0]            bcd_out,
    output logic [NUM_DIGITS-1:0] digit_n,
    output logic                  frame_done
);

    localparam int unsigned DWELL = CLK_HZ / DIGIT_HZ;

    // A gap of at least one cycle keeps the reset state (GAP, all digits off)
    // consistent with a counter value of zero.
    if (GAP_CYCLES < 1 || DWELL < GAP_CYCLES + 2) begin : g_bad_timing
        $error("seven_seg_scan_driver: need DWELL >= GAP_CYCLES+2 and GAP_CYCLES >= 1");
    end

    scan_state_e           state;
    scan_state_e           state_next;
    logic [NUM_DIGITS-1:0] digit_n_next;

    bcd4_t      display;
    bcd4_t      display_next;
    bcd4_t      pending;
    logic       pending_full;
    logic       accept;
    logic       swap;
    logic       blank;

    digit_idx_t idx;
    digit_idx_t idx_following;
    logic       slot_start;
    logic       gap_end;
    logic       frame_end;

    seven_seg_refresh_timer #(
        .DWELL      (DWELL),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .idx        (idx),
        .slot_start (slot_start),
        .gap_end    (gap_end),
        .frame_end  (frame_end)
    );

    assign accept        = host.in_valid && host.in_ready;
    assign swap          = frame_end && pending_full;
    assign display_next  = swap ? pending : display;
    assign idx_following = idx + 1'b1;

`ifdef SEVEN_SEG_LZ_BLANK_EN
    // Display only changes at frame boundaries, so sampling it at the end of
    // the gap matches the value in force at slot start.
    assign blank = leading_zero(display, idx);
`else
    assign blank = 1'b0;
`endif

    // Scan state register and registered digit enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= GAP;
            digit_n <= '1;
        end else begin
            state   <= state_next;
            digit_n <= digit_n_next;
        end
    end

    // Next scan state and digit enables: light the digit when the gap ends,
    // turn everything off when the slot wraps.
    always_comb begin
        state_next   = state;
        digit_n_next = digit_n;
        unique case (state)
            GAP: begin
                if (gap_end) begin
                    state_next   = ON;
                    digit_n_next = blank ? '1 : digit_enable_n(idx);
                end
            end
            ON: begin
                if (slot_start) begin
                    state_next   = GAP;
                    digit_n_next = '1;
                end
            end
        endcase
    end

    // Input handshake, pending slot and display register.
    // in_ready follows pending_full one cycle late, except that an accept
    // drops it immediately; accept (pending empty) and swap (pending full)
    // can therefore never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display       <= '0;
            pending       <= '0;
            pending_full  <= 1'b0;
            host.in_ready <= 1'b1;
        end else begin
            display <= display_next;
            if (accept) begin
                pending      <= host.in_data;
                pending_full <= 1'b1;
            end else if (swap) begin
                pending_full <= 1'b0;
            end
            host.in_ready <= accept ? 1'b0 : !pending_full;
        end
    end

    // Load the next slot's nibble at slot start and flag the end of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_out    <= '0;
            frame_done <= 1'b0;
        end else begin
            if (slot_start) begin
                bcd_out <= nibble_at(display_next, idx_following);
            end
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (DWELL=10, GAP_CYCLES=2).
// Cycle t counts from reset release; outputs are sampled on the falling edge.
module tb_seven_seg_scan_driver;

    localparam int unsigned CLK_HZ   = 1000;
    localparam int unsigned DIGIT_HZ = 100;
    localparam int unsigned GAP_CYC  = 2;
    localparam int          DWELL    = 10;
    localparam int          FRAME    = 40;

`ifdef SEVEN_SEG_LZ_BLANK_EN
    localparam bit LZ_EN = 1'b1;
`else
    localparam bit LZ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] bcd_out;
    logic [3:0] digit_n;
    logic       frame_done;

    seven_seg_scan_driver_if host();

    seven_seg_scan_driver #(
        .CLK_HZ     (CLK_HZ),
        .DIGIT_HZ   (DIGIT_HZ),
        .GAP_CYCLES (GAP_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host       (host),
        .bcd_out    (bcd_out),
        .digit_n    (digit_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int t        = 0;

    // Reference model: frame-level view of what should be on the display.
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_pend_v;
    int          m_pend_f;
    int          m_busy_from;
    int          m_busy_until;
    bit          m_accepted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    function automatic bit lz_blank(input logic [15:0] disp, input int slot);
        return LZ_EN && slot != 0 && ((disp >> (4 * slot)) == 16'h0);
    endfunction

    task automatic model_reset();
        t            = 0;
        m_disp       = 16'h0;
        m_pend       = 16'h0;
        m_pend_v     = 1'b0;
        m_pend_f     = 0;
        m_busy_from  = 0;
        m_busy_until = -1;
        m_accepted   = 1'b0;
    endtask

    // Compare every output at cycle t against the model, account for a
    // possible transfer at the closing edge, then move to cycle t+1.
    task automatic step();
        int         pos;
        int         slot;
        logic [3:0] one_hot;
        logic [3:0] exp_dn;
        bit         exp_rdy;
        if (m_pend_v && t == m_pend_f) begin
            m_disp   = m_pend;
            m_pend_v = 1'b0;
        end
        pos     = t % DWELL;
        slot    = (t / DWELL) % 4;
        one_hot = 4'b0001 << slot;
        if (pos < int'(GAP_CYC) || lz_blank(m_disp, slot)) exp_dn = 4'b1111;
        else exp_dn = ~one_hot;
        exp_rdy = !(t >= m_busy_from && t <= m_busy_until);
        check("digit_n", 32'(digit_n), 32'(exp_dn));
        check("bcd_out", 32'(bcd_out), 32'((m_disp >> (4 * slot)) & 16'hF));
        check("frame_done", 32'(frame_done), 32'(t > 0 && t % FRAME == 0));
        check("in_ready", 32'(host.in_ready), 32'(exp_rdy));
        m_accepted = 1'b0;
        if (exp_rdy && host.in_valid) begin
            m_accepted   = 1'b1;
            m_pend       = host.in_data;
            m_pend_v     = 1'b1;
            m_pend_f     = ((t + 1) / FRAME + 1) * FRAME;
            m_busy_from  = t + 1;
            m_busy_until = m_pend_f;
        end
        @(negedge clk);
        t++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        host.in_valid = 1'b0;
        host.in_data  = 16'h0;
        @(negedge clk);
        check("rst_digit_n", 32'(digit_n), 32'hF);
        check("rst_bcd_out", 32'(bcd_out), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_in_ready", 32'(host.in_ready), 32'h1);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) begin
            host.in_valid = 1'b0;
            host.in_data  = 16'($urandom);
            step();
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic [15:0] slot_bcd;   // expected bcd_out per slot, slot 0 in [3:0]
        logic [15:0] on_dn_lz;   // expected ON digit_n per slot with blanking
    } vec_t;

    localparam logic [15:0] ON_DN_PLAIN = 16'h7BDE;

    vec_t vecs[9];

    initial begin
        host.in_valid = 1'b0;
        host.in_data  = 16'h0;
        model_reset();

        vecs[0] = '{data: 16'h1234, slot_bcd: 16'h1234, on_dn_lz: 16'h7BDE};
        vecs[1] = '{data: 16'h0070, slot_bcd: 16'h0070, on_dn_lz: 16'hFFDE};
        vecs[2] = '{data: 16'h00FA, slot_bcd: 16'h00FA, on_dn_lz: 16'hFFDE};
        vecs[3] = '{data: 16'h0000, slot_bcd: 16'h0000, on_dn_lz: 16'hFFFE};
        vecs[4] = '{data: 16'h9999, slot_bcd: 16'h9999, on_dn_lz: 16'h7BDE};
        vecs[5] = '{data: 16'h0005, slot_bcd: 16'h0005, on_dn_lz: 16'hFFFE};
        vecs[6] = '{data: 16'h0100, slot_bcd: 16'h0100, on_dn_lz: 16'hFBDE};
        vecs[7] = '{data: 16'h1000, slot_bcd: 16'h1000, on_dn_lz: 16'h7BDE};
        vecs[8] = '{data: 16'h0A00, slot_bcd: 16'h0A00, on_dn_lz: 16'hFBDE};

        // Table: accept at cycle 5, inspect the frame starting at cycle 40.
        for (int v = 0; v < 9; v++) begin
            logic [15:0] dn_tab;
            dn_tab = LZ_EN ? vecs[v].on_dn_lz : ON_DN_PLAIN;
            do_reset();
            for (int c = 0; c < 80; c++) begin
                int slot;
                slot = (t / DWELL) % 4;
                host.in_valid = (t == 5);
                host.in_data  = (t == 5) ? vecs[v].data : 16'($urandom);
                if (t == 6)  check("tbl_ready_low", 32'(host.in_ready), 32'h0);
                if (t == 41) check("tbl_ready_back", 32'(host.in_ready), 32'h1);
                if (t == 40) check("tbl_frame_done", 32'(frame_done), 32'h1);
                if (t >= 40 && t % DWELL == 5) begin
                    check("tbl_bcd", 32'(bcd_out), 32'(vecs[v].slot_bcd[4*slot +: 4]));
                    check("tbl_on_dn", 32'(digit_n), 32'(dn_tab[4*slot +: 4]));
                end
                if (t >= 40 && t % DWELL == 1) check("tbl_gap_dn", 32'(digit_n), 32'hF);
                step();
            end
        end

        // Back-to-back: 5678 then 9999 held with valid.
        begin
            bit sent_a;
            bit sent_b;
            sent_a = 1'b0;
            sent_b = 1'b0;
            do_reset();
            for (int c = 0; c < 130; c++) begin
                if (t < 3 || sent_b) begin
                    host.in_valid = 1'b0;
                    host.in_data  = 16'h0;
                end else begin
                    host.in_valid = 1'b1;
                    host.in_data  = sent_a ? 16'h9999 : 16'h5678;
                end
                if (t == 4)  check("b2b_ready_low", 32'(host.in_ready), 32'h0);
                if (t == 41) check("b2b_ready_back", 32'(host.in_ready), 32'h1);
                if (t == 42) check("b2b_second_taken", 32'(host.in_ready), 32'h0);
                if (t == 45) check("b2b_first_d0", 32'(bcd_out), 32'h8);
                if (t == 75) check("b2b_first_d3", 32'(bcd_out), 32'h5);
                if (t == 85) check("b2b_second_d0", 32'(bcd_out), 32'h9);
                step();
                if (m_accepted) begin
                    if (sent_a) sent_b = 1'b1;
                    else sent_a = 1'b1;
                end
            end
        end

        // Accept in the same cycle as the frame boundary: shown one frame later.
        do_reset();
        for (int c = 0; c < 120; c++) begin
            host.in_valid = (t == 39);
            host.in_data  = 16'h4321;
            if (t == 40)  check("bnd_ready_low", 32'(host.in_ready), 32'h0);
            if (t == 45)  check("bnd_not_yet", 32'(bcd_out), 32'h0);
            if (t == 81)  check("bnd_ready_back", 32'(host.in_ready), 32'h1);
            if (t == 85)  check("bnd_d0", 32'(bcd_out), 32'h1);
            if (t == 115) check("bnd_d3", 32'(bcd_out), 32'h4);
            step();
        end

        // Asynchronous reset during the digit-2 ON slot with ABCD pending.
        do_reset();
        while (t < 65) begin
            host.in_valid = (t == 5) || (t == 45);
            host.in_data  = (t == 45) ? 16'hABCD : 16'h1234;
            step();
        end
        host.in_valid = 1'b0;
        check("mid_pre_dn", 32'(digit_n), 32'hB);
        check("mid_pre_ready", 32'(host.in_ready), 32'h0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_async_dn", 32'(digit_n), 32'hF);
        check("mid_async_ready", 32'(host.in_ready), 32'h1);
        check("mid_async_bcd", 32'(bcd_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 90; c++) begin
            host.in_valid = 1'b0;
            if (t == 45 || t == 85) check("mid_no_pending", 32'(bcd_out), 32'h0);
            step();
        end

        // Randomised traffic against the model.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            for (int c = 0; c < 1000; c++) begin
                host.in_valid = ($urandom_range(0, 2) == 0);
                host.in_data  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255))
                                                            : 16'($urandom);
                step();
            end
        end

        run_idle(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
